// File: rtl/iir_coeff_loader.sv
// Coefficient loader for the time-multiplexed 2nd-order IIR filter.
// The host fills shadow taps and a commit applies them all on a sample boundary.
// Optional registered tap readback: define IIR_COEFF_READBACK_EN.
module iir_coeff_loader #(
    parameter int HOST_WIDTH     = 16,
    parameter int COEFF_WIDTH    = 35,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          wr_en_in,
    input  logic [4:0]                    wr_addr_in,
    input  logic [HOST_WIDTH-1:0]         wr_data_in,
    input  logic                          commit_in,
    input  logic                          on_req_in,
    input  logic                          sample_tick_in,
    input  logic [2:0]                    rd_addr_in,
    output logic signed [COEFF_WIDTH-1:0] a1_out,
    output logic signed [COEFF_WIDTH-1:0] a2_out,
    output logic signed [COEFF_WIDTH-1:0] b0_out,
    output logic signed [COEFF_WIDTH-1:0] b1_out,
    output logic signed [COEFF_WIDTH-1:0] b2_out,
    output logic                          on_out,
    output logic                          commit_pending_out,
    output logic                          commit_done_out,
    output logic                          err_out,
    output logic [COEFF_WIDTH-1:0]        rd_data_out
);
    localparam int NUM_TAPS = 5;
    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam int TOP_W    = COEFF_WIDTH - 2*HOST_WIDTH;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   on_pend;
    logic [COEFF_WIDTH-1:0] shadow [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] active [NUM_TAPS];

    logic [2:0] tap_idx;
    logic [1:0] word_sel;
    logic       addr_ok;
    logic       apply;

    assign tap_idx  = wr_addr_in[4:2];
    assign word_sel = wr_addr_in[1:0];
    assign addr_ok  = (tap_idx < 3'(NUM_TAPS)) && (word_sel != 2'd3);
    // An idle filter produces no ticks, so there is nothing to align to.
    assign apply    = (state == PENDING) &&
                      (!on_out || sample_tick_in || cnt == CNT_W'(TIMEOUT_CYCLES-1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state              <= IDLE;
            cnt                <= '0;
            on_pend            <= 1'b0;
            on_out             <= 1'b0;
            commit_pending_out <= 1'b0;
            commit_done_out    <= 1'b0;
            err_out            <= 1'b0;
            for (int t = 0; t < NUM_TAPS; t++) begin
                shadow[t] <= '0;
                active[t] <= '0;
            end
        end else begin
            commit_done_out <= 1'b0;

            if (wr_en_in) begin
                if (!addr_ok || state != IDLE) begin
                    err_out <= 1'b1;
                end else begin
                    for (int t = 0; t < NUM_TAPS; t++) begin
                        if (tap_idx == 3'(t)) begin
                            case (word_sel)
                                2'd0:    shadow[t][HOST_WIDTH-1:0] <= wr_data_in;
                                2'd1:    shadow[t][2*HOST_WIDTH-1:HOST_WIDTH] <= wr_data_in;
                                default: shadow[t][COEFF_WIDTH-1:2*HOST_WIDTH] <= wr_data_in[TOP_W-1:0];
                            endcase
                        end
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (commit_in) begin
                        on_pend            <= on_req_in;
                        cnt                <= '0;
                        commit_pending_out <= 1'b1;
                        state              <= PENDING;
                    end
                end
                PENDING: begin
                    cnt <= cnt + 1'b1;
                    if (apply) begin
                        for (int t = 0; t < NUM_TAPS; t++) active[t] <= shadow[t];
                        on_out             <= on_pend;
                        commit_done_out    <= 1'b1;
                        commit_pending_out <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a1_out = active[0];
    assign a2_out = active[1];
    assign b0_out = active[2];
    assign b1_out = active[3];
    assign b2_out = active[4];

`ifdef IIR_COEFF_READBACK_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_data_out <= '0;
        end else begin
            rd_data_out <= '0;
            for (int t = 0; t < NUM_TAPS; t++)
                if (rd_addr_in == 3'(t)) rd_data_out <= active[t];
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr_in;
    assign rd_data_out    = '0;
`endif

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: expected applied tap sets go into a queue,
// a monitor pops and compares on every commit_done_out pulse.
module tb_iir_coeff_loader;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        wr_en_in;
    logic [4:0]  wr_addr_in;
    logic [15:0] wr_data_in;
    logic        commit_in;
    logic        on_req_in;
    logic        sample_tick_in;
    logic [2:0]  rd_addr_in;
    logic [34:0] a1_out, a2_out, b0_out, b1_out, b2_out, rd_data_out;
    logic        on_out, commit_pending_out, commit_done_out, err_out;

    typedef struct packed {
        logic [34:0] a1, a2, b0, b1, b2;
        logic        on;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, n_push = 0, n_done = 0;

    iir_coeff_loader #(.HOST_WIDTH(16), .COEFF_WIDTH(35), .TIMEOUT_CYCLES(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in), .commit_in(commit_in), .on_req_in(on_req_in),
        .sample_tick_in(sample_tick_in), .rd_addr_in(rd_addr_in),
        .a1_out(a1_out), .a2_out(a2_out), .b0_out(b0_out), .b1_out(b1_out), .b2_out(b2_out),
        .on_out(on_out), .commit_pending_out(commit_pending_out),
        .commit_done_out(commit_done_out), .err_out(err_out), .rd_data_out(rd_data_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [15:0] data);
        wr_en_in = 1'b1; wr_addr_in = addr; wr_data_in = data;
        step();
        wr_en_in = 1'b0;
    endtask

    task automatic commit(input logic on);
        commit_in = 1'b1; on_req_in = on;
        step();
        commit_in = 1'b0; on_req_in = 1'b0;
    endtask

    task automatic push(input exp_t e);
        sb.push_back(e);
        n_push++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " a1"}, a1_out, 0);
        check({tag, " a2"}, a2_out, 0);
        check({tag, " b0"}, b0_out, 0);
        check({tag, " b1"}, b1_out, 0);
        check({tag, " b2"}, b2_out, 0);
        check({tag, " on"}, on_out, 0);
        check({tag, " pending"}, commit_pending_out, 0);
        check({tag, " done"}, commit_done_out, 0);
        check({tag, " err"}, err_out, 0);
        check({tag, " rd_data"}, rd_data_out, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk_in) begin
        if (!rst_in && commit_done_out) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected commit_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb a1", a1_out, e.a1);
                check("sb a2", a2_out, e.a2);
                check("sb b0", b0_out, e.b0);
                check("sb b1", b1_out, e.b1);
                check("sb b2", b2_out, e.b2);
                check("sb on", on_out, e.on);
            end
        end
    end

    initial begin
        int pend_cyc;
        bit seen;
        rst_in = 1'b1; wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;
        commit_in = 1'b0; on_req_in = 1'b0; sample_tick_in = 1'b0; rd_addr_in = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst_in = 1'b0;
        step();

        // Filter off: a1 = 4_0000_0001, done exactly 2 cycles after commit
        wr(5'b00000, 16'h0001); wr(5'b00001, 16'h0000); wr(5'b00010, 16'h0004);
        push('{a1: 35'h4_0000_0001, a2: 0, b0: 0, b1: 0, b2: 0, on: 1'b1});
        commit(1'b1);
        check("off N+1 done", commit_done_out, 0);
        check("off N+1 pending", commit_pending_out, 1);
        step();
        check("off N+2 done", commit_done_out, 1);
        check("off N+2 pending", commit_pending_out, 0);
        step();
        check("off done single", commit_done_out, 0);

        // Filter on: b0 applies on the tick, pending for 11 cycles
        wr(5'b01000, 16'h5678); wr(5'b01001, 16'h1234); wr(5'b01010, 16'h0000);
        push('{a1: 35'h4_0000_0001, a2: 0, b0: 35'h0_1234_5678, b1: 0, b2: 0, on: 1'b1});
        commit(1'b1);
        for (int i = 1; i <= 11; i++) begin
            check("tick pending", commit_pending_out, 1);
            check("tick b0 held", b0_out, 0);
            if (i == 11) sample_tick_in = 1'b1;
            step();
        end
        sample_tick_in = 1'b0;
        check("tick done", commit_done_out, 1);
        check("tick b0 new", b0_out, 35'h0_1234_5678);
        check("tick pending low", commit_pending_out, 0);

        // Timeout: no tick, apply after 16 pending cycles
        wr(5'b01100, 16'hABCD);
        push('{a1: 35'h4_0000_0001, a2: 0, b0: 35'h0_1234_5678, b1: 35'h0_0000_ABCD, b2: 0, on: 1'b1});
        commit(1'b1);
        pend_cyc = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (commit_done_out) begin seen = 1; break; end
            if (commit_pending_out) pend_cyc++;
            step();
        end
        check("timeout done seen", seen, 1);
        check("timeout pending cycles", pend_cyc, 16);
        step();
        check("timeout done single", commit_done_out, 0);

        // Write during PENDING is dropped and flagged
        check("err before drop", err_out, 0);
        wr(5'b00000, 16'h00AA);
        push('{a1: 35'h4_0000_00AA, a2: 0, b0: 35'h0_1234_5678, b1: 35'h0_0000_ABCD, b2: 0, on: 1'b0});
        commit(1'b0);
        wr(5'b00000, 16'hFFFF);
        check("drop err", err_out, 1);
        check("drop a1 active", a1_out, 35'h4_0000_0001);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        check("drop done", commit_done_out, 1);
        check("drop a1 applied", a1_out, 35'h4_0000_00AA);
        step();

        // Reset clears everything including sticky err
        rst_in = 1'b1;
        #2;
        check_all_zero("rst2");
        step();
        rst_in = 1'b0;
        step();

        // Invalid addresses: no tap changes, err set
        wr(5'b10100, 16'h1234);
        wr(5'b00011, 16'h1234);
        check("bad addr err", err_out, 1);
        push('{a1: 0, a2: 0, b0: 0, b1: 0, b2: 0, on: 1'b1});
        commit(1'b1);
        step();
        check("bad addr done", commit_done_out, 1);

        // Reset in the middle of PENDING loses the commit
        wr(5'b00100, 16'h0055);
        commit(1'b1);
        step();
        check("mid pending", commit_pending_out, 1);
        #2 rst_in = 1'b1;
        #1;
        check_all_zero("rst mid");
        step();
        rst_in = 1'b0;
        repeat (3) step();
        check("after rst pending", commit_pending_out, 0);

        // Back in IDLE: writes accepted without error
        wr(5'b00100, 16'h0077);
        check("idle write err", err_out, 0);
        push('{a1: 0, a2: 35'h0_0000_0077, b0: 0, b1: 0, b2: 0, on: 1'b0});
        commit(1'b0);
        step();
        check("post rst done", commit_done_out, 1);

        // Readback of b2
        wr(5'b10000, 16'hFFFF); wr(5'b10001, 16'hFFFF); wr(5'b10010, 16'hFFFF);
        push('{a1: 0, a2: 35'h0_0000_0077, b0: 0, b1: 0, b2: 35'h7_FFFF_FFFF, on: 1'b1});
        commit(1'b1);
        step();
        check("b2 applied", b2_out, 35'h7_FFFF_FFFF);
        rd_addr_in = 3'd4;
        step();
`ifdef IIR_COEFF_READBACK_EN
        check("rd b2", rd_data_out, 35'h7_FFFF_FFFF);
        rd_addr_in = 3'd6;
        step();
        check("rd idx6", rd_data_out, 0);
`else
        check("rd disabled", rd_data_out, 0);
`endif
        step();

        check("sb empty", sb.size(), 0);
        check("done count", n_done, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Host-side writer for the time-multiplexed 2nd-order IIR filter's coefficient and enable inputs (a1, a2, b0, b1, b2, on).
- Host writes 35-bit signed taps as 16-bit words into shadow registers.
- A commit transfers all taps plus the enable to the active outputs in one cycle, aligned to the filter's sample boundary, so the filter never mixes old and new taps within one output update.

Parameters:
- HOST_WIDTH, 16, host data word width (fixed; taps are built from three words).
- COEFF_WIDTH, 35, tap width driven to the filter.
- TIMEOUT_CYCLES, 1024, max cycles a pending commit waits for sample_tick_in before applying anyway (>= 2).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous reset, active-high
- wr_en_in  input  1  host write strobe, one word per cycle
- wr_addr_in  input  5  [4:2] tap index (0=a1, 1=a2, 2=b0, 3=b1, 4=b2); [1:0] word (0=bits 15:0, 1=bits 31:16, 2=bits 34:32 from data[2:0])
- wr_data_in  input  16  host write data
- commit_in  input  1  single-cycle commit request
- on_req_in  input  1  filter enable value applied at commit
- sample_tick_in  input  1  pulse from filter when it latches a new sample
- rd_addr_in  input  3  readback tap index (see Optional Feature)
- a1_out, a2_out, b0_out, b1_out, b2_out  output  35 each  active signed taps
- on_out  output  1  active filter enable
- commit_pending_out  output  1  high while a commit waits
- commit_done_out  output  1  one-cycle pulse when taps are applied
- err_out  output  1  sticky: dropped write or invalid address
- rd_data_out  output  35  readback data

Behaviour:
- Reset (async): all shadow and active taps 0, on_out 0, commit_pending_out 0, commit_done_out 0, err_out 0, rd_data_out 0, FSM in IDLE, timeout counter 0.
- Writes: accepted only in IDLE, updating the addressed 16-bit or 3-bit slice of the shadow tap. Word 2 uses data[2:0] only; data[15:3] is ignored.
- Invalid address (tap index > 4 or word == 3): write ignored, err_out set.
- Write while not IDLE: dropped, err_out set.
- err_out clears only on reset.
- FSM IDLE: on commit_in, latch on_req_in into on_pend, clear the counter, go to PENDING. commit_pending_out goes high at the next edge.
- FSM PENDING: the counter increments each cycle. Apply when any of these holds:
  - on_out == 0 (filter idle, no ticks will arrive);
  - sample_tick_in == 1;
  - counter == TIMEOUT_CYCLES-1.
- Apply edge: all five active taps <= shadow; on_out <= on_pend; commit_done_out <= 1 for one cycle; commit_pending_out <= 0; return to IDLE.
- A tick coincident with commit_in in IDLE is not used; the apply waits for the next tick.
- Latency when on_out == 0: commit_in high in cycle N gives new active taps and commit_done_out in cycle N+2.
- commit_in while PENDING is ignored, with no error.
- Active taps change only on the apply edge; outputs are pure registers with no combinational path from the host.
- Reset mid-PENDING: the commit is lost and everything returns to reset values.

Optional Feature:
- Macro: IIR_COEFF_READBACK_EN.
- Defined: rd_data_out is registered each cycle from the active tap selected by rd_addr_in, 1-cycle latency. Indices 5-7 return 0.
- Not defined: rd_data_out is held at 0 and rd_addr_in is unused.

Test Plan:
- Filter off: write a1 = 35'h4_0000_0001 (words 0x0001, 0x0000, 0x0004), commit with on_req_in=1 -> a1_out = 35'h4_0000_0001, on_out = 1, commit_done_out pulse exactly 2 cycles after commit_in; other taps remain 0.
- on_out=1: write b0 = 35'h0_1234_5678 and commit, tick 10 cycles later -> b0_out unchanged until the tick edge, then updates together with commit_done_out; commit_pending_out high for 11 cycles.
- on_out=1, TIMEOUT_CYCLES=16, no tick -> apply 16 cycles after entering PENDING; commit_done_out pulses once.
- Write during PENDING (addr 5'b00000, data 0xFFFF) -> shadow unchanged, err_out = 1, applied a1_out equals the pre-commit shadow value.
- Write to addr 5'b10100 and 5'b00011 -> no tap changes, err_out = 1; assert rst_in mid-PENDING -> all outputs 0, FSM IDLE.
- With IIR_COEFF_READBACK_EN: after applying b2 = 35'h7_FFFF_FFFF, rd_addr_in = 4 -> rd_data_out = 35'h7_FFFF_FFFF one cycle later; rd_addr_in = 6 -> 0.
